snake_body_ctrl: RTL and testbench

//  Upstream controller for the free-running DEPTH-stage 2-bit direction shift register (no enable).
//  - Drives sr_in every cycle; recirculates sr_out, so the register acts as a DEPTH-slot ring.
//  - On each game step, writes the new head direction into the free slot just ahead of the head.
//  - Tracks head slot and body length; captures the tail direction for the tail-position logic.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_ring_cursor.sv | 48 ++++
 rtl/snake_body_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the snake body controller slice.
//   dir_t        : 2-bit segment direction (UP, RIGHT, DOWN, LEFT)
//   SNAKE_DEPTH  : default ring depth (must match the external shift register)
//   len_t/slot_t : body-length and ring-slot widths for the default depth
// -----------------------------------------------------------------------------
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  localparam int SNAKE_DEPTH  = 234;

  // Length counts 0..DEPTH inclusive, so it needs one more code than a slot.
  localparam int SNAKE_LEN_W  = $clog2(SNAKE_DEPTH + 1);
  localparam int SNAKE_SLOT_W = $clog2(SNAKE_DEPTH);

  typedef logic [SNAKE_LEN_W-1:0]  len_t;
  typedef logic [SNAKE_SLOT_W-1:0] slot_t;

endpackage : snake_pkg

// File: rtl/snake_ring_cursor.sv
// -----------------------------------------------------------------------------
// snake_ring_cursor
// Free-running mod-DEPTH counter. It tracks which ring slot is currently
// presented at the shift-register output.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous reset, active-low (phase -> 0)
//   clr    in   synchronous clear (phase -> 0 on the next edge)
//   phase  out  current slot number, 0..DEPTH-1
//   wrap   out  high while phase == DEPTH-1 (last slot of the revolution)
// DEPTH must be at least 2.
// -----------------------------------------------------------------------------
module snake_ring_cursor
  import snake_pkg::*;
#(
  parameter int  DEPTH = SNAKE_DEPTH,
  localparam int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  output logic [W-1:0] phase,
  output logic         wrap
);

  logic [W-1:0] phase_q;
  logic [W-1:0] phase_d;

  always_comb begin
    wrap = (phase_q == W'(DEPTH - 1));
    if (clr || wrap) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule : snake_ring_cursor

// File: rtl/snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// snake_body_ctrl
// Upstream controller for a free-running DEPTH-stage 2-bit shift register that
// holds the snake body. The register has no enable, so sr_out is fed back to
// sr_in every cycle and the register behaves as a DEPTH-slot ring. A game step
// writes the new head direction into the slot just ahead of the current head.
//
// Build option: define SNAKE_BODY_STREAM_EN to drive the seg_* stream ports;
// without it those ports are tied to zero.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous reset, active-low
//   step       in   one-cycle request to advance the snake (honoured in IDLE)
//   grow       in   sampled with step: keep the tail (length +1)
//   head_dir   in   sampled with step: direction of the new head segment
//   sr_out     in   last stage of the shift register (ring slot == phase)
//   sr_in      out  first stage of the shift register
//   busy       out  init or step in progress; step is dropped while high
//   done       out  one-cycle pulse when the new head is written
//   full       out  len == DEPTH
//   len        out  current body length
//   tail_dir   out  direction held in the tail segment (refreshed once per lap)
//   seg_valid  out  sr_out holds a live body segment        (stream build)
//   seg_idx    out  segment index at sr_out, 0 = head        (stream build)
//   seg_dir    out  copy of sr_out                           (stream build)
// -----------------------------------------------------------------------------
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int   DEPTH    = SNAKE_DEPTH,
  parameter int   INIT_LEN = 3,
  parameter dir_t INIT_DIR = RIGHT,
  localparam int  LEN_W    = $clog2(DEPTH + 1),
  localparam int  SLOT_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              grow,
  input  logic [1:0]        head_dir,
  input  logic [1:0]        sr_out,
  output logic [1:0]        sr_in,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [LEN_W-1:0]  len,
  output logic [1:0]        tail_dir,
  output logic              seg_valid,
  output logic [SLOT_W-1:0] seg_idx,
  output logic [1:0]        seg_dir
);

  // WRITE is never stored: it is the WAIT cycle in which the cursor reaches
  // the free slot, so the write and the done pulse happen in that same cycle.
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [SLOT_W-1:0] head_slot_q, head_slot_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [1:0]        tail_dir_q,  tail_dir_d;
  logic              grow_q,      grow_d;
  logic [1:0]        dir_q,       dir_d;

  logic [SLOT_W-1:0] phase;
  logic              wrap;
  logic [SLOT_W-1:0] idx;
  logic [SLOT_W-1:0] w_slot;
  logic              tail_hit;
  logic [1:0]        st_eff;

  snake_ring_cursor #(
    .DEPTH (DEPTH)
  ) u_cursor (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .phase (phase),
    .wrap  (wrap)
  );

  assign full = (len_q == LEN_W'(DEPTH));

  // Ring geometry relative to the current head.
  always_comb begin
    // (phase - head) mod DEPTH; the true result is always below DEPTH, so
    // plain SLOT_W-bit wrap-around arithmetic gives the right answer.
    if (phase >= head_slot_q) begin
      idx = phase - head_slot_q;
    end else begin
      idx = phase - head_slot_q + SLOT_W'(DEPTH);
    end

    // The free slot just ahead of the head: (head - 1) mod DEPTH.
    if (head_slot_q == '0) begin
      w_slot = SLOT_W'(DEPTH - 1);
    end else begin
      w_slot = head_slot_q - SLOT_W'(1);
    end

    tail_hit = (LEN_W'(idx) == (len_q - LEN_W'(1)));
  end

  always_comb begin
    st_eff = state_q;
    if ((state_q == ST_WAIT) && (phase == w_slot)) begin
      st_eff = ST_WRITE;
    end
  end

  always_comb begin
    state_d     = state_q;
    head_slot_d = head_slot_q;
    len_d       = len_q;
    tail_dir_d  = tail_dir_q;
    grow_d      = grow_q;
    dir_d       = dir_q;
    sr_in       = sr_out;
    done        = 1'b0;

    case (st_eff)
      ST_INIT: begin
        // Phase starts at 0 after reset, so one full lap fills every slot.
        sr_in = INIT_DIR;
        if (wrap) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (step) begin
          // A grow request on a full ring degrades to a plain move.
          grow_d  = grow & ~full;
          dir_d   = head_dir;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Recirculate until the cursor reaches the free slot.
      end
      ST_WRITE: begin
        // Without grow the old tail slot simply drops out of the live range;
        // when full that slot is w_slot itself and gets overwritten here.
        sr_in       = dir_q;
        head_slot_d = w_slot;
        len_d       = len_q + LEN_W'(grow_q);
        done        = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Ring contents are unknown until the init lap has written them, so the
    // reset value of tail_dir is kept until the ring is valid.
    if ((state_q != ST_INIT) && tail_hit) begin
      tail_dir_d = sr_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      head_slot_q <= '0;
      len_q       <= LEN_W'(INIT_LEN);
      tail_dir_q  <= INIT_DIR;
      grow_q      <= 1'b0;
      dir_q       <= INIT_DIR;
    end else begin
      state_q     <= state_d;
      head_slot_q <= head_slot_d;
      len_q       <= len_d;
      tail_dir_q  <= tail_dir_d;
      grow_q      <= grow_d;
      dir_q       <= dir_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign len      = len_q;
  assign tail_dir = tail_dir_q;

`ifdef SNAKE_BODY_STREAM_EN
  always_comb begin
    seg_valid = (state_q != ST_INIT) && (LEN_W'(idx) < len_q);
    seg_idx   = idx;
    seg_dir   = sr_out;
  end
`else
  assign seg_valid = 1'b0;
  assign seg_idx   = '0;
  assign seg_dir   = 2'd0;
`endif

endmodule : snake_body_ctrl

// File: tb/tb_snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_body_ctrl
// Pairs snake_body_ctrl with a behavioural 234-stage shift register and keeps
// an expected body (head first) to compare the ring contents against.
// -----------------------------------------------------------------------------
module tb_snake_body_ctrl;

  localparam int D = 234;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       step     = 1'b0;
  logic       grow     = 1'b0;
  logic [1:0] head_dir = 2'd0;
  logic [1:0] sr_out;
  logic [1:0] sr_in;
  logic       busy;
  logic       done;
  logic       full;
  logic [7:0] len;
  logic [1:0] tail_dir;
  logic       seg_valid;
  logic [7:0] seg_idx;
  logic [1:0] seg_dir;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural shift register and slot counter.
  logic [1:0] sr [D];
  int         bph = 0;

  // Expected body, index 0 = head, and expected head slot.
  logic [1:0] body [$];
  int         head_m = 0;

  always #5 clk = ~clk;

  assign sr_out = sr[D-1];

  always @(posedge clk) begin
    sr[0] <= sr_in;
    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    if (!rst_n) bph <= 0;
    else        bph <= (bph == D - 1) ? 0 : bph + 1;
  end

  snake_body_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .grow      (grow),
    .head_dir  (head_dir),
    .sr_out    (sr_out),
    .sr_in     (sr_in),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .len       (len),
    .tail_dir  (tail_dir),
    .seg_valid (seg_valid),
    .seg_idx   (seg_idx),
    .seg_dir   (seg_dir)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contents of ring slot s as held in the model right now.
  function automatic logic [1:0] slot_val(input int s);
    int k;
    k = (s - bph + D) % D;
    return sr[D-1-k];
  endfunction

  function automatic int ring_bad();
    int bad;
    bad = 0;
    for (int k = 0; k < body.size(); k++)
      if (slot_val((head_m + k) % D) !== body[k]) bad++;
    return bad;
  endfunction

  function automatic int count_not(input logic [1:0] v);
    int bad;
    bad = 0;
    for (int s = 0; s < D; s++)
      if (slot_val(s) !== v) bad++;
    return bad;
  endfunction

  task automatic model_reset();
    body.delete();
    for (int i = 0; i < 3; i++) body.push_back(2'd1);
    head_m = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  // Issue one step from IDLE and check latency and resulting length.
  task automatic do_step(input logic g, input logic [1:0] d);
    int  p, w, exp_lat, lat;
    bit  grow_eff;
    lat = 0;
    while (busy !== 1'b0 && lat < 2 * D) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL step_idle: busy=%0b, required 0", busy);
    end
    p        = bph;
    w        = (head_m + D - 1) % D;
    exp_lat  = (w - p + D) % D;
    if (exp_lat == 0) exp_lat = D;
    grow_eff = g && (body.size() < D);
    step = 1'b1; grow = g; head_dir = d;
    tick();
    step = 1'b0; grow = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat <= D + 2) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL step_latency: got %0d cycles, required %0d", lat, exp_lat);
    end
    body.push_front(d);
    if (!grow_eff) void'(body.pop_back());
    head_m = w;
    tick();
    n_cmp++;
    if (len !== 8'(body.size())) begin
      n_bad++;
      $display("FAIL step_len: len=%0d, required %0d", len, body.size());
    end
    $display("step dir=%0d grow=%0b latency=%0d len=%0d", d, g, lat, len);
  endtask

  // 1. Reset values, init lap length, ring filled with RIGHT.
  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy=%0b done=%0b full=%0b, required 1 0 0", busy, done, full);
    end
    n_cmp++;
    if (len !== 8'd3 || tail_dir !== 2'd1 || sr_in !== 2'd1) begin
      n_bad++;
      $display("FAIL reset_values: len=%0d tail_dir=%0d sr_in=%0d, required 3 1 1", len, tail_dir, sr_in);
    end
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    for (int c = 0; c < 240; c++) begin
      if (busy === 1'b1) cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 234) begin
      n_bad++;
      $display("FAIL init_busy_cycles: got %0d, required 234", cnt);
    end
    n_cmp++;
    if (busy !== 1'b0 || len !== 8'd3 || tail_dir !== 2'd1) begin
      n_bad++;
      $display("FAIL post_init: busy=%0b len=%0d tail_dir=%0d, required 0 3 1", busy, len, tail_dir);
    end
    n_cmp++;
    if (count_not(2'd1) !== 0) begin
      n_bad++;
      $display("FAIL init_ring: %0d slots not RIGHT, required 0", count_not(2'd1));
    end
    $display("reset: busy cycles=%0d len=%0d", cnt, len);
  endtask

  // 2. Plain move UP, plus one lap of stream/tail observation.
  task automatic test_move();
    int bad, idx;
    do_step(1'b0, 2'd0);
    n_cmp++;
    if (slot_val(head_m) !== 2'd0 || slot_val((head_m + 1) % D) !== 2'd1 ||
        slot_val((head_m + 2) % D) !== 2'd1) begin
      n_bad++;
      $display("FAIL move_body: idx0..2=%0d %0d %0d, required 0 1 1", slot_val(head_m),
               slot_val((head_m + 1) % D), slot_val((head_m + 2) % D));
    end
    bad = 0;
    for (int c = 0; c < D + 1; c++) begin
      idx = (bph - head_m + D) % D;
`ifdef SNAKE_BODY_STREAM_EN
      if (seg_valid !== (idx < body.size()) || seg_idx !== 8'(idx) || seg_dir !== sr_out) bad++;
`else
      if (seg_valid !== 1'b0 || seg_idx !== 8'd0 || seg_dir !== 2'd0) bad++;
`endif
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL stream_ports: %0d bad cycles in one lap, required 0", bad);
    end
    n_cmp++;
    if (tail_dir !== 2'd1) begin
      n_bad++;
      $display("FAIL move_tail: tail_dir=%0d, required 1", tail_dir);
    end
  endtask

  // 3. Five growing steps from a fresh body.
  task automatic test_grow();
    logic [1:0] dirs [5];
    logic [1:0] exp8 [8];
    int bad;
    dirs = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    exp8 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1};
    apply_reset();
    for (int i = 0; i < 5; i++) do_step(1'b1, dirs[i]);
    n_cmp++;
    if (len !== 8'd8) begin
      n_bad++;
      $display("FAIL grow_len: len=%0d, required 8", len);
    end
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (slot_val((head_m + k) % D) !== exp8[k]) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL grow_body: %0d of 8 segments wrong, required 0", bad);
    end
  endtask

  // Plain moves drop tail segments; tail_dir follows within one lap.
  task automatic test_tail_follow();
    for (int i = 0; i < 3; i++) do_step(1'b0, 2'd1);
    repeat (D + 1) tick();
    n_cmp++;
    if (tail_dir !== 2'd0) begin
      n_bad++;
      $display("FAIL tail_follow: tail_dir=%0d, required 0", tail_dir);
    end
    n_cmp++;
    if (ring_bad() !== 0) begin
      n_bad++;
      $display("FAIL tail_follow_ring: %0d segments wrong, required 0", ring_bad());
    end
  endtask

  // 4. Extra step pulses while busy are dropped.
  task automatic test_busy_ignore();
    int ndone, w;
    w = (head_m + D - 1) % D;
    step = 1'b1; grow = 1'b1; head_dir = 2'd2;
    tick();
    step = 1'b0;
    ndone = 0;
    for (int c = 0; c < 2 * D + 4; c++) begin
      if (done === 1'b1) ndone++;
      step = (busy === 1'b1) && c[0];
      head_dir = 2'd3;
      tick();
      step = 1'b0;
    end
    grow = 1'b0;
    body.push_front(2'd2);
    head_m = w;
    n_cmp++;
    if (ndone !== 1) begin
      n_bad++;
      $display("FAIL busy_done_count: got %0d, required 1", ndone);
    end
    n_cmp++;
    if (len !== 8'd9 || slot_val(head_m) !== 2'd2) begin
      n_bad++;
      $display("FAIL busy_len_head: len=%0d head=%0d, required 9 2", len, slot_val(head_m));
    end
    $display("busy_ignore: dones=%0d len=%0d", ndone, len);
  endtask

  // 5. Fill the ring, then a grow step on a full ring acts as a move.
  task automatic test_full();
    for (int i = 0; body.size() < D; i++) begin
      if (body.size() == D - 1) begin
        n_cmp++;
        if (full !== 1'b0) begin
          n_bad++;
          $display("FAIL full_early: full=%0b at len=%0d, required 0", full, len);
        end
      end
      do_step(1'b1, 2'(i % 4));
    end
    n_cmp++;
    if (full !== 1'b1 || len !== 8'd234) begin
      n_bad++;
      $display("FAIL full_flag: full=%0b len=%0d, required 1 234", full, len);
    end
    do_step(1'b1, 2'd3);
    n_cmp++;
    if (full !== 1'b1 || slot_val(head_m) !== 2'd3) begin
      n_bad++;
      $display("FAIL full_move: full=%0b head=%0d, required 1 3", full, slot_val(head_m));
    end
    repeat (D + 1) tick();
    n_cmp++;
    if (ring_bad() !== 0) begin
      n_bad++;
      $display("FAIL full_ring: %0d segments wrong, required 0", ring_bad());
    end
    n_cmp++;
    if (tail_dir !== body[body.size() - 1]) begin
      n_bad++;
      $display("FAIL full_tail: tail_dir=%0d, required %0d", tail_dir, body[body.size() - 1]);
    end
  endtask

  // 6. Reset while a step is pending in WAIT.
  task automatic test_reset_mid();
    int ndone;
    step = 1'b1; grow = 1'b1; head_dir = 2'd2;
    tick();
    step = 1'b0; grow = 1'b0;
    ndone = 0;
    repeat (5) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_wait_busy: busy=%0b, required 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    n_cmp++;
    if (busy !== 1'b1 || len !== 8'd3 || full !== 1'b0 || tail_dir !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_reset_values: busy=%0b len=%0d full=%0b tail=%0d, required 1 3 0 1",
               busy, len, full, tail_dir);
    end
    for (int c = 0; c < 240; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_done: %0d done pulses, required 0", ndone);
    end
    n_cmp++;
    if (busy !== 1'b0 || len !== 8'd3 || count_not(2'd1) !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_init: busy=%0b len=%0d bad_slots=%0d, required 0 3 0",
               busy, len, count_not(2'd1));
    end
    $display("reset_mid: dones=%0d len=%0d", ndone, len);
  endtask

  initial begin
    test_reset();
    test_move();
    test_grow();
    test_tail_follow();
    test_busy_ignore();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_snake_body_ctrl
